debug_responder: RTL
====================

// Module: debug_responder
// PURPOSE
//  Command responder on the UART debug link between the host PC and the MIPS core.
//  Takes command bytes from Receptor (senial_ticks_completos/salida_receptor).
//  Decodes each command, drives the MIPS run/step controls, and returns reply bytes
//  through Transmisor (comienzo_TX/entrada_transmisor, done via senial_ticks_completos).
//  Sits in the top level in place of the receive->transmit loopback.
// PARAMETERS
//  ancho_dato  8      UART data byte width
//  NB          32     MIPS PC width; must be a multiple of ancho_dato
//  CMD_PC      8'h50  'P': read PC
//  CMD_STEP    8'h53  'S': single step
//  CMD_RUN     8'h52  'R': run
//  CMD_HALT    8'h48  'H': halt
//  ACK_BYTE    8'h06  reply to accepted S/R/H
//  NAK_BYTE    8'h15  reply to unknown command
// PORTS
//  clk            in   1           system clock
//  reset          in   1           asynchronous, active-high reset
//  i_rx_ready     in   1           1-cycle pulse: byte received
//  i_rx_data      in   ancho_dato  received byte; valid while i_rx_ready=1
//  i_tx_done      in   1           1-cycle pulse: transmitter finished a byte
//  i_mips_pc      in   NB          current MIPS PC
//  o_tx_start     out  1           1-cycle pulse: start sending o_tx_data
//  o_tx_data      out  ancho_dato  byte to send; held stable from o_tx_start until i_tx_done
//  o_mips_step    out  1           1-cycle step pulse to the core
//  o_mips_run     out  1           level: core free-running
//  o_state_debug  out  3           current FSM state encoding
// BEHAVIOUR
//  Reset (async, any cycle):
//   - State goes to IDLE.
//   - o_tx_start=0, o_tx_data=0, o_mips_step=0, o_mips_run=0.
//   - Byte counter and PC snapshot cleared.
//   - Reset mid-reply aborts the reply. No further bytes are sent.
//  States and transitions:
//   - IDLE(0): on i_rx_ready, latch i_rx_data, go to DECODE.
//   - DECODE(1), one cycle:
//     - P: snapshot i_mips_pc, reply = NB/8 bytes, LSB byte first.
//     - S: pulse o_mips_step this cycle; reply = ACK.
//     - R: set o_mips_run=1; reply = ACK.
//     - H: set o_mips_run=0; reply = ACK.
//     - Any other byte: reply = NAK.
//     - Then go to SEND.
//   - SEND(2): o_tx_start=1 for exactly this cycle, o_tx_data = current byte. Go to WAIT.
//   - WAIT(3): hold o_tx_data until i_tx_done.
//     - More bytes pending: go to NEXT.
//     - Otherwise: go to IDLE.
//   - NEXT(4): advance byte index (shift the snapshot right by ancho_dato). Go to SEND.
//  Latency:
//   - i_rx_ready at cycle N gives o_tx_start at N+2.
//   - i_tx_done at cycle M gives the next o_tx_start at M+2.
//   - The next command is accepted from the cycle after the final i_tx_done.
//  Boundaries:
//   - The PC is snapshotted once, in DECODE. Later PC changes do not affect the reply.
//   - i_rx_ready outside IDLE: byte dropped, no state change. No queueing.
//   - i_tx_done outside WAIT: ignored.
//   - i_rx_ready in the same cycle the final i_tx_done returns the FSM to IDLE: dropped.
//   - S while o_mips_run=1: step pulse still issued, o_mips_run unchanged.
//   - R while already running and H while halted: idempotent, ACK still sent.
//   - Byte index wraps only via return to IDLE. The index width must hold NB/8+1.
// CONFIGURATION
//  Macro DEBUG_RESPONDER_CHECKSUM_EN:
//   - Defined: a P reply gets one extra trailing byte after the NB/8 PC bytes.
//     That byte is the XOR of all PC bytes (5 bytes total for NB=32).
//     ACK and NAK replies are unchanged.
//   - Undefined: a P reply is exactly NB/8 bytes. No checksum logic is synthesised.
// TESTING
//  - Reset assert mid-WAIT: all outputs 0 within the same cycle, o_state_debug=0.
//    After release, no o_tx_start until a new command arrives.
//  - PC read: i_mips_pc=32'h0000FFA3, rx 8'h50, tx_done 20 cycles after each start.
//    Tx bytes are A3,FF,00,00. The first o_tx_start is 2 cycles after i_rx_ready.
//    With CHECKSUM_EN, a 5th byte 5C follows.
//  - Step and run: rx 8'h53 gives o_mips_step high exactly 1 cycle and tx 06.
//    Then rx 8'h52 gives o_mips_run=1 and tx 06. Then rx 8'h48 gives o_mips_run=0 and tx 06.
//  - Unknown command: rx 8'h7A gives a single tx 15, with run and step unchanged.
//  - Busy drop: during a P reply, inject rx 8'h53. No step pulse, reply still 4 bytes,
//    FSM back to IDLE after the last done.
//  - Snapshot: change i_mips_pc to 32'h12345678 after DECODE.
//    The reply still carries the original value.

Source files
------------

// File: rtl/debug_responder.sv
// UART debug-link command responder: decodes host commands, drives MIPS run/step, sends replies.
// Optional DEBUG_RESPONDER_CHECKSUM_EN appends an XOR checksum byte to PC replies.
module debug_responder #(
  parameter int unsigned ancho_dato = 8,
  parameter int unsigned NB         = 32,
  parameter logic [ancho_dato-1:0] CMD_PC   = 8'h50,
  parameter logic [ancho_dato-1:0] CMD_STEP = 8'h53,
  parameter logic [ancho_dato-1:0] CMD_RUN  = 8'h52,
  parameter logic [ancho_dato-1:0] CMD_HALT = 8'h48,
  parameter logic [ancho_dato-1:0] ACK_BYTE = 8'h06,
  parameter logic [ancho_dato-1:0] NAK_BYTE = 8'h15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_rx_ready,
  input  logic [ancho_dato-1:0] i_rx_data,
  input  logic                  i_tx_done,
  input  logic [NB-1:0]         i_mips_pc,
  output logic                  o_tx_start,
  output logic [ancho_dato-1:0] o_tx_data,
  output logic                  o_mips_step,
  output logic                  o_mips_run,
  output logic [2:0]            o_state_debug
);

  localparam int unsigned NBYTES = NB / ancho_dato;
`ifdef DEBUG_RESPONDER_CHECKSUM_EN
  localparam int unsigned PBYTES = NBYTES + 1;
`else
  localparam int unsigned PBYTES = NBYTES;
`endif
  localparam int unsigned SW = PBYTES * ancho_dato;
  localparam int unsigned IW = $clog2(NBYTES + 2);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StDecode = 3'd1;
  localparam logic [2:0] StSend   = 3'd2;
  localparam logic [2:0] StWait   = 3'd3;
  localparam logic [2:0] StNext   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ancho_dato-1:0] cmd_q, cmd_d;
  logic [SW-1:0]         shreg_q, shreg_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         last_q, last_d;
  logic                  run_q, run_d;
  logic [SW-1:0]         pc_reply;

`ifdef DEBUG_RESPONDER_CHECKSUM_EN
  logic [ancho_dato-1:0] csum;

  always_comb begin
    csum = '0;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      csum ^= i_mips_pc[b*ancho_dato +: ancho_dato];
    end
    pc_reply = {csum, i_mips_pc};
  end
`else
  always_comb begin
    pc_reply = i_mips_pc;
  end
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    last_d  = last_q;
    run_d   = run_q;
    case (state_q)
      StIdle: begin
        if (i_rx_ready) begin
          cmd_d   = i_rx_data;
          idx_d   = '0;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // Reply register is loaded here, so the PC is snapshotted exactly once.
        last_d  = '0;
        shreg_d = SW'(ACK_BYTE);
        if (cmd_q == CMD_PC) begin
          shreg_d = pc_reply;
          last_d  = IW'(PBYTES - 1);
        end else if (cmd_q == CMD_STEP) begin
          shreg_d = SW'(ACK_BYTE);
        end else if (cmd_q == CMD_RUN) begin
          run_d = 1'b1;
        end else if (cmd_q == CMD_HALT) begin
          run_d = 1'b0;
        end else begin
          shreg_d = SW'(NAK_BYTE);
        end
        state_d = StSend;
      end
      StSend: state_d = StWait;
      StWait: begin
        if (i_tx_done) begin
          state_d = (idx_q != last_q) ? StNext : StIdle;
        end
      end
      StNext: begin
        idx_d   = idx_q + IW'(1);
        shreg_d = shreg_q >> ancho_dato;
        state_d = StSend;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      shreg_q <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      run_q   <= run_d;
    end
  end

  assign o_tx_start    = (state_q == StSend);
  assign o_tx_data     = shreg_q[ancho_dato-1:0];
  assign o_mips_step   = (state_q == StDecode) && (cmd_q == CMD_STEP);
  assign o_mips_run    = run_q;
  assign o_state_debug = state_q;

endmodule
